// File: rtl/ghost_dir_gen.sv
// Per-ghost pseudo-random direction picker driven by a shared 16-bit LFSR.
// Each ghost re-picks on its own period timer or on a junction request, honouring its wall mask.
module ghost_dir_gen #(
    parameter int NUM_GHOSTS = 4,
    parameter int PERIOD_W   = 24,
    parameter bit NO_REVERSE = 1'b1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    enable,
    input  logic [PERIOD_W-1:0]     period,
    input  logic [4*NUM_GHOSTS-1:0] blocked,
    input  logic [NUM_GHOSTS-1:0]   req,
    output logic [8*NUM_GHOSTS-1:0] dir,
    output logic [NUM_GHOSTS-1:0]   dir_valid
);

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Direction indices: 0 = L, 1 = R, 2 = D, 3 = U. Reverse of any index is index ^ 1.
    function automatic logic [7:0] code_of(input logic [1:0] idx);
        logic [7:0] code;
        case (idx)
            2'd0:    code = 8'h04;
            2'd1:    code = 8'h07;
            2'd2:    code = 8'h16;
            default: code = 8'h1A;
        endcase
        return code;
    endfunction

    // Returns {picked, idx}; picked = 0 means the ghost is fully enclosed and holds.
    function automatic logic [2:0] pick(input logic [1:0] cur, input logic [3:0] blk,
                                        input logic [1:0] k);
        logic [3:0] allowed;
        logic [1:0] rev;
        logic [1:0] cand;
        logic [1:0] idx;
        logic       found;
        rev     = cur ^ 2'd1;
        allowed = ~blk;
        if (NO_REVERSE) allowed[rev] = 1'b0;
        found = 1'b0;
        idx   = cur;
        for (int j = 0; j < 4; j++) begin
            cand = k + 2'(j);
            if (!found && allowed[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        if (!found && !blk[rev]) begin
            found = 1'b1;
            idx   = rev;
        end
        return {found, idx};
    endfunction

    logic [15:0]         lfsr;
    logic [15:0]         lfsr_next;
    logic [PERIOD_W-1:0] cnt      [NUM_GHOSTS];
    logic [1:0]          cur_idx  [NUM_GHOSTS];
    logic [1:0]          next_idx [NUM_GHOSTS];
    logic [NUM_GHOSTS-1:0] ev;
    logic [NUM_GHOSTS-1:0] pick_ok;
    logic [PERIOD_W-1:0] thresh;
    logic [2:0]          pick_res;

    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    // period of 0 behaves like 1, so the threshold saturates at 0.
    assign thresh = (period == '0) ? '0 : period - PERIOD_W'(1);

    always_comb begin
        ev       = '0;
        pick_ok  = '0;
        pick_res = '0;
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            next_idx[i] = cur_idx[i];
            ev[i]       = (enable && (cnt[i] >= thresh)) || req[i];
            pick_res    = pick(cur_idx[i], blocked[4*i +: 4], lfsr[2*i +: 2]);
            pick_ok[i]  = pick_res[2];
            next_idx[i] = pick_res[1:0];
        end
    end

    // dir_valid is a one-cycle strobe with no back-pressure: it is high in exactly the
    // cycle after a successful pick, and dir slice i is valid to consume in that cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lfsr      <= LFSR_SEED;
            dir_valid <= '0;
            for (int i = 0; i < NUM_GHOSTS; i++) begin
                cnt[i]     <= '0;
                cur_idx[i] <= 2'd0;
            end
        end else begin
            lfsr <= lfsr_next;
            for (int i = 0; i < NUM_GHOSTS; i++) begin
                if (ev[i]) begin
                    cnt[i] <= '0;
                end else if (enable) begin
                    cnt[i] <= cnt[i] + PERIOD_W'(1);
                end
                dir_valid[i] <= ev[i] && pick_ok[i];
                if (ev[i] && pick_ok[i]) cur_idx[i] <= next_idx[i];
            end
        end
    end

    always_comb begin
        dir = '0;
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            dir[8*i +: 8] = code_of(cur_idx[i]);
        end
    end

endmodule

// File: doc/ghost_dir_gen.md
# ghost_dir_gen

Multi-channel pseudo-random direction generator for the ghost movement logic. It produces one direction code per ghost, using the same key-code encoding as player input: left 8'h04, right 8'h07, down 8'h16, up 8'h1A. Each ghost picks a new direction on its own periodic timer or on a junction request. The pick respects a per-ghost wall mask and, optionally, a no-reverse rule. It sits between the maze/collision logic, which supplies `blocked` and `req`, and the ghost position registers, which consume `dir`.

## Interface
- `NUM_GHOSTS`, 4: number of independent channels, legal range 1..8.
- `PERIOD_W`, 24: width of the per-ghost period counter and of the `period` input.
- `NO_REVERSE`, 1: when 1, the direction opposite the current one is excluded from normal picks.

- `Clk` in 1: single clock; every register is rising-edge.
- `Reset` in 1: synchronous, active-high.
- `enable` in 1: gates the periodic timers; has no effect on `req` handling.
- `period` in `PERIOD_W`: cycles between periodic re-picks, shared by all ghosts; a value of 0 is treated as 1.
- `blocked` in `4*NUM_GHOSTS`: wall mask; slice [4i+3:4i] belongs to ghost i; bit 0 = L, bit 1 = R, bit 2 = D, bit 3 = U; 1 means blocked.
- `req` in `NUM_GHOSTS`: junction request; forces an immediate pick for that ghost.
- `dir` out `8*NUM_GHOSTS`: current direction code; slice [8i+7:8i] belongs to ghost i.
- `dir_valid` out `NUM_GHOSTS`: one-cycle pulse marking each cycle in which that ghost's `dir` changes value or is re-loaded.

## Operation
- **LFSR**
  - One shared 16-bit Fibonacci LFSR, taps 16/14/13/11.
  - Shift order: left shift; the new bit 0 is lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10].
  - Steps every cycle, whether or not `enable` is high; holds 16'hACE1 while `Reset` is high.
  - Ghost i draws its candidate index k = lfsr[2i+1:2i], using the pre-shift value of the event cycle.
  - Index-to-direction mapping: 0 = L, 1 = R, 2 = D, 3 = U.
- **Per-ghost counter** (`PERIOD_W` bits)
  - Increments while `enable` is high and holds while it is low.
  - A periodic event fires when `enable` is high and cnt >= max(`period`,1)-1.
  - The comparison is >=, so lowering `period` mid-count fires on the next enabled cycle rather than wrapping.
  - Any event for that ghost, periodic or `req`, clears its counter to 0.
- **Event**
  - event_i = periodic_i OR req[i].
  - Coincident `req` and period expiry produce a single event and a single pulse.
  - Ghosts are fully independent; any subset may have events in the same cycle.
- **Pick** for ghost i, with current direction c and opposite rev(c) (L↔R, D↔U):
  - allowed = ~blocked_i, with the rev(c) bit also cleared when `NO_REVERSE`=1.
  - If allowed is non-zero: choose the first set bit scanning k, k+1, k+2, k+3 (mod 4).
  - Else if rev(c) is not blocked (dead end): choose rev(c).
  - Else (fully enclosed): hold c, pulse nothing, and still clear the counter.
- **Output update:** on a successful pick, `dir` takes the new code and `dir_valid` pulses, even when the new code equals the old one.

## Timing
- **Reset values:** every `dir` slice = 8'h04, `dir_valid` = 0, all counters 0, LFSR = 16'hACE1.
- **Reset mid-operation:** overrides everything on that edge. A `req` present during `Reset` is dropped.
- **Latency:** an event condition sampled at edge t updates `dir` and `dir_valid` after edge t, so they are visible in cycle t+1. `dir_valid` is high for exactly that one cycle.
- **Period spacing:** with `enable` held high and `period`=P, ghost i pulses every P cycles. The first pulse comes P cycles after `Reset` falls.
- **Combinational inputs:** `blocked` and `req` are used combinationally in the event cycle; there is no input registering.
- **Request handshake:** a `req` held high re-picks and pulses every cycle.
- **Counter wrap:** cannot occur, since an event clears the counter before it overflows. `period`=0 behaves exactly like `period`=1.

## Test plan
- **Reset values:** assert `Reset` for 3 cycles, then release with `enable`=0 and `req`=0 → every `dir` slice = 8'h04, `dir_valid`=0, and no pulses for 100 cycles.
- **Periodic spacing:** `period`=4, `enable`=1, `blocked`=0 → each ghost's `dir_valid` pulses every 4 cycles. Drop `enable` for 10 cycles → pulses stop; restore it → the count resumes from the held value.
- **First pick from the seeded LFSR:** `NO_REVERSE`=1, first cycle after reset, `req[0]`=1, `blocked`=0.
  - LFSR = 16'hACE1 gives k=1 (R), which is excluded as the reverse of L.
  - Required response: `dir[7:0]`=8'h16 with `dir_valid[0]`=1 in the next cycle.
- **Wall mask:** ghost 0 currently L, `blocked[3:0]`=4'b1110, `req[0]` pulsed 20 times at random spacing → every pick yields 8'h04.
- **Dead end and full enclosure:** ghost 0 currently L, `NO_REVERSE`=1.
  - `blocked[3:0]`=4'b1101 → `dir`=8'h07 (dead end, reverse taken).
  - `blocked[3:0]`=4'b1111 → `dir` unchanged, no `dir_valid` pulse, and the counter is still cleared.
- **Coincident events and mid-operation reset:** `period`=3, with `req[1]` asserted exactly on the expiry cycle → one pulse, and the next periodic pulse comes 3 cycles later. Assert `Reset` together with `req[2]` → no pulse, and `dir[23:16]`=8'h04.
